// File: rtl/lector_contadores.sv
// Readout sequencer for the counter bank: waits for the transaction FSM to go idle,
// walks every counter index, hands each count to the probador and latches the sweep sum.
module lector_contadores #(
  parameter int NUM_CNT = 4,
  parameter int DATA_W  = 5,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    idle,
  output logic                    cnt_req,
  output logic [IDX_W-1:0]        cnt_idx,
  input  logic [DATA_W-1:0]       cnt_data,
  input  logic                    cnt_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W+IDX_W-1:0] total,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int ACC_W = DATA_W + IDX_W;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_OUT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;
  logic [ACC_W-1:0]   acc;
  logic               timeout_hit;
  logic               xfer;
  logic               last_ptr;

  // Accumulator is wide enough for NUM_CNT full-scale counts, so no saturation is needed.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
    return a + ACC_W'(d);
  endfunction

  assign timeout_hit = (state == S_WAIT) && !idle && (timer == TMR_LAST);
  assign xfer        = (state == S_OUT) && rd_ready;
  assign last_ptr    = (ptr == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_WAIT;
      S_WAIT: begin
        if (idle)             state_nxt = S_REQ;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_REQ:  state_nxt = cnt_valid ? S_OUT : S_WAIT;
      S_OUT: begin
        if (xfer) state_nxt = last_ptr ? S_DONE : S_REQ;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of registered state so the bank sees no glitches.
  always_comb begin
    cnt_req  = 1'b0;
    cnt_idx  = '0;
    rd_valid = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_WAIT: err = timeout_hit;
      S_REQ: begin
        cnt_req = 1'b1;
        cnt_idx = ptr;
      end
      S_OUT:  rd_valid = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      timer   <= '0;
      acc     <= '0;
      rd_data <= '0;
      rd_idx  <= '0;
      total   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr   <= '0;
            acc   <= '0;
            timer <= '0;
          end
        end
        S_WAIT: begin
          if (!idle) timer <= timer + 1'b1;
        end
        S_REQ: begin
          // A missing response means the transaction FSM left idle; retry this index.
          if (cnt_valid) begin
            rd_data <= cnt_data;
            rd_idx  <= ptr;
            acc     <= acc_add(acc, cnt_data);
          end else begin
            timer <= '0;
          end
        end
        S_OUT: begin
          if (rd_ready && !last_ptr) ptr <= ptr + 1'b1;
        end
        S_DONE: total <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lector_contadores.sv
// Scoreboard bench for lector_contadores: stimulus pushes expected (idx,data) pairs and
// sweep totals; a negedge monitor pops and compares on each transfer and done pulse.
module tb_lector_contadores;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       idle;
  logic       cnt_req;
  logic [1:0] cnt_idx;
  logic [4:0] cnt_data;
  logic       cnt_valid;
  logic [4:0] rd_data;
  logic [1:0] rd_idx;
  logic       rd_valid;
  logic       rd_ready;
  logic [6:0] total;
  logic       busy;
  logic       done;
  logic       err;

  logic [4:0] cnt_mem [4];

  typedef struct {
    int idx;
    int data;
  } rd_t;

  rd_t exp_q[$];
  int  tot_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  bit  tot_pend = 1'b0;

  lector_contadores dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .idle      (idle),
    .cnt_req   (cnt_req),
    .cnt_idx   (cnt_idx),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .total     (total),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Counter bank model: combinational response, valid only while the FSM is idle.
  assign cnt_data  = cnt_mem[cnt_idx];
  assign cnt_valid = cnt_req & idle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_bank(input int a, input int b, input int c, input int d);
    cnt_mem[0] = 5'(a);
    cnt_mem[1] = 5'(b);
    cnt_mem[2] = 5'(c);
    cnt_mem[3] = 5'(d);
  endtask

  task automatic push_sweep(input int exp_total);
    for (int i = 0; i < 4; i++) begin
      rd_t e;
      e.idx  = i;
      e.data = int'(cnt_mem[i]);
      exp_q.push_back(e);
    end
    tot_q.push_back(exp_total);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tot_q.size() != 0 || busy || tot_pend) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s drain: still pending after %0d cycles (queue %0d, totals %0d)",
               name, n, exp_q.size(), tot_q.size());
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: compares every accepted transfer and the total after every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tot_pend) begin
        tot_pend = 1'b0;
        checks++;
        if (tot_q.size() == 0) begin
          errors++;
          $display("FAIL total: unexpected done, total %0d with nothing expected", total);
        end else begin
          int e;
          e = tot_q.pop_front();
          if (int'(total) != e) begin
            errors++;
            $display("FAIL total: got %0d expected %0d at %0t", total, e, $time);
          end
        end
      end
      if (done) begin
        done_cnt++;
        tot_pend = 1'b1;
      end
      if (err) err_cnt++;
      if (rd_valid && rd_ready && !rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_xfer: unexpected transfer idx %0d data %0d", rd_idx, rd_data);
        end else begin
          rd_t e;
          e = exp_q.pop_front();
          if (int'(rd_idx) != e.idx || int'(rd_data) != e.data) begin
            errors++;
            $display("FAIL rd_xfer: got (%0d,%0d) expected (%0d,%0d) at %0t",
                     rd_idx, rd_data, e.idx, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    idle     = 1'b1;
    rd_ready = 1'b1;
    load_bank(3, 0, 31, 7);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt_req", int'(cnt_req), 0);
    chk("rst_cnt_idx", int'(cnt_idx), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_idx", int'(rd_idx), 0);
    chk("rst_total", int'(total), 0);
    chk("rst_done_err", int'({done, err}), 0);

    // T1: plain sweep with latency checks
    push_sweep(41);
    pulse_start();
    chk("t1_busy", int'(busy), 1);
    chk("t1_wait_no_req", int'(cnt_req), 0);
    tick();
    chk("t1_req", int'(cnt_req), 1);
    chk("t1_req_idx", int'(cnt_idx), 0);
    tick();
    chk("t1_rd_valid", int'(rd_valid), 1);
    chk("t1_first_data", int'(rd_data), 3);
    drain("t1");
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_total", int'(total), 41);

    // T2: idle held low, timeout on the 15th cycle in S_WAIT
    idle = 1'b0;
    pulse_start();
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("t2_no_err_c%0d", k), int'(err), 0);
      chk($sformatf("t2_no_req_c%0d", k), int'(cnt_req), 0);
      tick();
    end
    chk("t2_err_c15", int'(err), 1);
    chk("t2_busy_c15", int'(busy), 1);
    tick();
    chk("t2_busy_after", int'(busy), 0);
    chk("t2_err_after", int'(err), 0);
    repeat (5) tick();
    chk("t2_stays_idle", int'(busy), 0);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_total_kept", int'(total), 41);
    idle = 1'b1;

    // T3: idle drops during the request for idx 1, returns after 4 cycles
    load_bank(5, 9, 2, 11);
    push_sweep(27);
    pulse_start();
    tick();
    tick();
    tick();
    chk("t3_req1", int'(cnt_req), 1);
    chk("t3_req1_idx", int'(cnt_idx), 1);
    idle = 1'b0;
    repeat (4) tick();
    chk("t3_waiting", int'(cnt_req), 0);
    idle = 1'b1;
    tick();
    chk("t3_rereq", int'(cnt_req), 1);
    chk("t3_rereq_idx", int'(cnt_idx), 1);
    drain("t3");
    chk("t3_done_cnt", done_cnt, 2);
    chk("t3_err_cnt", err_cnt, 1);

    // T4: back-pressure on idx 2
    load_bank(1, 2, 3, 4);
    push_sweep(10);
    pulse_start();
    begin
      int n = 0;
      while (!(rd_valid && rd_idx == 2'd2) && n < 20) begin
        tick();
        n++;
      end
      chk("t4_reach_idx2", int'(n < 20), 1);
    end
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_hold_valid_%0d", k), int'(rd_valid), 1);
      chk($sformatf("t4_hold_data_%0d", k), int'(rd_data), 3);
      chk($sformatf("t4_hold_idx_%0d", k), int'(rd_idx), 2);
      tick();
    end
    rd_ready = 1'b1;
    chk("t4_still_data", int'(rd_data), 3);
    drain("t4");
    chk("t4_done_cnt", done_cnt, 3);

    // T5: start re-pulsed mid-sweep, all counts at full scale
    load_bank(31, 31, 31, 31);
    push_sweep(124);
    pulse_start();
    tick();
    tick();
    chk("t5_in_out", int'(rd_valid), 1);
    pulse_start();
    drain("t5");
    repeat (3) tick();
    chk("t5_no_restart", int'(busy), 0);
    chk("t5_done_cnt", done_cnt, 4);
    chk("t5_total", int'(total), 124);

    // T6: reset during S_OUT of idx 1, then a fresh sweep
    load_bank(6, 7, 8, 9);
    push_sweep(30);
    pulse_start();
    tick();
    tick();
    tick();
    tick();
    chk("t6_out1_valid", int'(rd_valid), 1);
    chk("t6_out1_idx", int'(rd_idx), 1);
    rd_ready = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    rd_ready = 1'b1;
    exp_q.delete();
    tot_q.delete();
    chk("t6_busy", int'(busy), 0);
    chk("t6_rd_valid", int'(rd_valid), 0);
    chk("t6_rd_data", int'(rd_data), 0);
    chk("t6_rd_idx", int'(rd_idx), 0);
    chk("t6_total", int'(total), 0);
    chk("t6_req", int'({cnt_req, cnt_idx}), 0);
    d0 = done_cnt;
    push_sweep(30);
    pulse_start();
    tick();
    chk("t6_restart_idx", int'(cnt_idx), 0);
    drain("t6");
    chk("t6_done_cnt", done_cnt, d0 + 1);
    chk("t6_err_cnt", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
